// File: rtl/sys_bus_pkg.sv
// ----------------------------------------------------------------------------
// sys_bus_pkg
// Shared definitions for the system bus arbiter:
//   - region_e : address region codes (data memory, two devices, unmapped)
//   - region base/mask constants used by the address decoder
//   - state_e  : arbiter FSM states
//   - in_region: helper that tests an address against a base/mask pair
// Optional feature macro used by the arbiter: SYS_BUS_ERR_EN.
// ----------------------------------------------------------------------------
package sys_bus_pkg;

    typedef enum logic [1:0] {
        REGION_MEM  = 2'd0,
        REGION_DEV1 = 2'd1,
        REGION_DEV2 = 2'd2,
        REGION_NONE = 2'd3
    } region_e;

    // Data memory occupies 0x0000_0000-0x0000_00FF.
    localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MEM_MASK  = 32'hFFFF_FF00;
    // Each device owns a 16-byte window.
    localparam logic [31:0] DEV1_BASE = 32'h0000_0800;
    localparam logic [31:0] DEV2_BASE = 32'h0000_0900;
    localparam logic [31:0] DEV_MASK  = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/sys_bus_region.sv
// ----------------------------------------------------------------------------
// sys_bus_region
// Purely combinational address decoder: maps a 32-bit address to a region
// code (MEM / DEV1 / DEV2 / NONE).
// Ports:
//   addr_i   [31:0] : address to classify
//   region_o [1:0]  : region code (sys_bus_pkg::region_e encoding)
// ----------------------------------------------------------------------------
module sys_bus_region
    import sys_bus_pkg::*;
(
    input  logic [31:0] addr_i,
    output logic [1:0]  region_o
);

    always_comb begin
        region_o = REGION_NONE;
        if (in_region(addr_i, MEM_BASE, MEM_MASK)) begin
            region_o = REGION_MEM;
        end else if (in_region(addr_i, DEV1_BASE, DEV_MASK)) begin
            region_o = REGION_DEV1;
        end else if (in_region(addr_i, DEV2_BASE, DEV_MASK)) begin
            region_o = REGION_DEV2;
        end
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// ----------------------------------------------------------------------------
// sys_bus_arbiter
// Two-master (CPU = m0, DMA = m1) round-robin arbiter for a single shared
// system bus. One transaction at a time: IDLE -> ACCESS -> DONE -> IDLE.
// The winning master's we/a/wd are latched on grant; ACCESS lasts WAIT+1
// cycles (WAIT chosen by address region), DONE issues the single write
// strobe and the one-cycle rdy pulse carrying read data.
// Parameters:
//   MEM_WAIT : wait cycles for the data-memory region
//   DEV_WAIT : wait cycles for device regions and any other address
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   m0_*/m1_* req,we,a,wd    : master request inputs
//   m0_gnt/m1_gnt            : grant, high from the cycle after arbitration
//                              through DONE
//   m0_rdy/m1_rdy            : one-cycle completion pulse
//   m_rd                     : read data, valid while a rdy is high, else 0
//   bus_we, bus_a, bus_wd    : shared bus towards the address decoder
//   bus_rd                   : read data from the slave mux
//   bus_err                  : only when SYS_BUS_ERR_EN is defined; flags an
//                              access to an unmapped address (with rdy), and
//                              the write strobe is suppressed for it
// ----------------------------------------------------------------------------
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int DEV_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_wd,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_wd,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rdy,
    output logic        m1_rdy,
    output logic [31:0] m_rd,
`ifdef SYS_BUS_ERR_EN
    output logic        bus_err,
`endif
    output logic        bus_we,
    output logic [31:0] bus_a,
    output logic [31:0] bus_wd,
    input  logic [31:0] bus_rd
);

    localparam logic [31:0] MEM_WAIT_C = 32'(MEM_WAIT);
    localparam logic [31:0] DEV_WAIT_C = 32'(DEV_WAIT);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;   // 0 = m0, 1 = m1
    logic        last_q,  last_d;    // master granted most recently
    logic        we_q,    we_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] wd_q,    wd_d;
    logic [31:0] cnt_q,   cnt_d;

    logic        any_req;
    logic        sel_m1;
    logic [31:0] sel_a;
    logic [1:0]  sel_region;
    logic        in_done;
    logic        busy;
    logic        err;

    // Round robin: m1 wins when it is the only requester, or when both
    // request and m0 was the last master served.
    assign any_req = m0_req | m1_req;
    assign sel_m1  = m1_req & (~m0_req | ~last_q);
    assign sel_a   = sel_m1 ? m1_a : m0_a;

    // Decode the address being latched so the wait count is known on entry
    // to ACCESS.
    sys_bus_region u_region (
        .addr_i   (sel_a),
        .region_o (sel_region)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        a_d     = a_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d = sel_m1;
                    last_d  = sel_m1;
                    we_d    = sel_m1 ? m1_we : m0_we;
                    a_d     = sel_a;
                    wd_d    = sel_m1 ? m1_wd : m0_wd;
                    cnt_d   = (sel_region == REGION_MEM) ? MEM_WAIT_C : DEV_WAIT_C;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // ACCESS spans WAIT+1 cycles: the cycle that sees zero
                // is the last one.
                if (cnt_q == 32'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;     // m0 wins the first tie after reset
            we_q    <= 1'b0;
            a_q     <= 32'd0;
            wd_q    <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SYS_BUS_ERR_EN
    logic [1:0] region_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            region_q <= REGION_MEM;
        end else if (state_q == ST_IDLE && any_req) begin
            region_q <= sel_region;
        end
    end

    assign err     = (region_q == REGION_NONE);
    assign bus_err = in_done & err;
`else
    assign err = 1'b0;
`endif

    // A reset arriving in the DONE cycle must not let the strobe or the
    // completion pulse escape, so DONE-qualified outputs are masked by rst.
    assign in_done = (state_q == ST_DONE) & ~rst;
    assign busy    = (state_q != ST_IDLE);

    assign m0_gnt = busy & ~owner_q;
    assign m1_gnt = busy &  owner_q;
    assign m0_rdy = in_done & ~owner_q;
    assign m1_rdy = in_done &  owner_q;
    assign m_rd   = in_done ? bus_rd : 32'd0;

    assign bus_we = in_done & we_q & ~err;
    assign bus_a  = busy ? a_q  : 32'd0;
    assign bus_wd = busy ? wd_q : 32'd0;

endmodule

// File: doc/sys_bus_arbiter.md
SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: wait cycles for the data-memory region (0x0000_0000-0x0000_00FF).
REQ-002 SHALL have parameter DEV_WAIT, default 1: wait cycles for the device regions (0x0000_080x, 0x0000_090x) and all other addresses.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports m0_req/m1_req, input, 1 each: access request from the CPU (m0) and the DMA (m1).
REQ-006 SHALL have ports m0_we/m1_we, input, 1: write request; m0_a/m1_a, input, 32: address; m0_wd/m1_wd, input, 32: write data.
REQ-007 SHALL have ports m0_gnt/m1_gnt, output, 1: grant; m0_rdy/m1_rdy, output, 1: one-cycle completion pulse; m_rd, output, 32: read data, valid while rdy is high.
REQ-008 SHALL have ports bus_we, output, 1; bus_a, output, 32; bus_wd, output, 32: the shared bus driven into the system address decoder.
REQ-009 SHALL have port bus_rd, input, 32: read data from the slave mux.

Function
REQ-010 SHALL implement the FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-011 In IDLE, when any req is high at an edge, SHALL select a master, latch its we/a/wd into holding registers, assert its gnt and enter ACCESS.
REQ-012 SHALL arbitrate round-robin: on simultaneous requests, the master not granted last wins.
REQ-013 SHALL load the wait counter with MEM_WAIT or DEV_WAIT, chosen by the latched address region, on entry to ACCESS.
REQ-014 SHALL, in ACCESS, decrement the counter each cycle and enter DONE in the cycle after the counter reads 0.
REQ-015 SHALL drive bus_a/bus_wd from the holding registers during ACCESS and DONE, and 0 in IDLE.
REQ-016 SHALL assert bus_we only in DONE and only for a latched write, giving exactly one write strobe per transaction.
REQ-017 SHALL, in DONE, pulse the granted master's rdy for one cycle, present bus_rd combinationally on m_rd, deassert gnt at the next edge and return to IDLE.
REQ-018 SHALL place req at edge k, gnt high from k+1, and rdy in cycle k+2+WAIT.
REQ-019 SHALL not re-arbitrate until the cycle after DONE, so back-to-back grants are separated by at least one IDLE cycle.
REQ-020 SHALL ignore req deassertion mid-transaction; the transaction completes and rdy still pulses.
REQ-021 SHALL ignore changes on master we/a/wd after latching.
REQ-022 SHALL drive m_rd to 0 whenever no rdy is high.

Reset
REQ-023 SHALL, on rst, force state=IDLE, gnt=0, rdy=0, bus_we=0, bus_a=0, bus_wd=0, counter=0, and round-robin pointer "last=m1" (so m0 wins the first tie).
REQ-024 SHALL abort an in-flight transaction on rst mid-operation with no bus_we strobe and no rdy pulse.

Configuration
REQ-025 SHALL, when macro SYS_BUS_ERR_EN is defined, add output bus_err (1): high with rdy in DONE when the latched address matches no region (not 0x0000_00xx, 0x0000_080x or 0x0000_090x), and suppress bus_we for that transaction.
REQ-026 SHALL, without SYS_BUS_ERR_EN, have no bus_err port and treat unmapped accesses as normal DEV_WAIT accesses.

Structure
REQ-027 SHALL place the region encoding (MEM/DEV1/DEV2/NONE), the region base constants and the FSM state typedef in shared package sys_bus_pkg.
REQ-028 SHALL use one combinational sub-module, sys_bus_region, mapping a 32-bit address to a region code, used by the arbiter.

Verification
REQ-029 Bench SHALL check: m0 read at 0x10 with MEM_WAIT=0 -> gnt at k+1, m0_rdy at k+2, m_rd=bus_rd, bus_we never high.
REQ-030 Bench SHALL check: m1 write 0xDEADBEEF to 0x804 with DEV_WAIT=1 -> m1_rdy at k+3, bus_we high exactly one cycle with bus_a=0x804, bus_wd=0xDEADBEEF.
REQ-031 Bench SHALL check: m0 and m1 requesting continuously from reset -> grant order m0, m1, m0, m1, with one IDLE cycle between grants.
REQ-032 Bench SHALL check: m0 drops req and changes m0_a during ACCESS -> transaction completes on the original address and m0_rdy still pulses.
REQ-033 Bench SHALL check: rst asserted in ACCESS of a write -> no bus_we strobe, no rdy, and all outputs 0 the next cycle.
REQ-034 Bench SHALL check, with SYS_BUS_ERR_EN: write to 0x1000 -> bus_err and m0_rdy high together for one cycle, bus_we stays 0.
